// File: rtl/hilo_unit_pkg.sv
// Shared funct codes and request decode for the HI/LO writeback pipeline.
// Function codes extend the standard funct set with the HI/LO group.
package hilo_unit_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_MULT,
        OP_MTHI,
        OP_MTLO
    } hilo_op_e;

    // Signed and unsigned multiplies write HI/LO the same way here.
    function automatic hilo_op_e decode_op(input logic valid, input logic [5:0] funct);
        hilo_op_e op;
        op = OP_NONE;
        if (valid) begin
            case (funct)
                FUNCT_MULT, FUNCT_MULTU: op = OP_MULT;
                FUNCT_MTHI:              op = OP_MTHI;
                FUNCT_MTLO:              op = OP_MTLO;
                default:                 op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/hilo_stage_reg.sv
// One pipeline entry {we_hi, we_lo, hi, lo}: holds on stall, empties on flush.
module hilo_stage_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  we_hi_i,
    input  logic                  we_lo_i,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    output logic                  we_hi_o,
    output logic                  we_lo_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    logic                  we_hi_q, we_lo_q;
    logic [DATA_WIDTH-1:0] hi_q, lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_hi_q <= 1'b0;
            we_lo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            we_hi_q <= 1'b0;
            we_lo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (!stall) begin
            we_hi_q <= we_hi_i;
            we_lo_q <= we_lo_i;
            hi_q    <= hi_i;
            lo_q    <= lo_i;
        end
    end

    assign we_hi_o = we_hi_q;
    assign we_lo_o = we_lo_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO pipeline tracker: carries multiply and MTHI/MTLO results through MEM and WB,
// commits at end of WB and forwards the youngest value to MFHI/MFLO in EX.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    ex_valid,
    input  logic [5:0]              ex_funct,
    input  logic [DATA_WIDTH-1:0]   ex_operand,
    input  logic [2*DATA_WIDTH-1:0] ex_product,
    output logic [DATA_WIDTH-1:0]   ex_rdata,
    output logic [DATA_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0]   lo
);

    logic                  req_we_hi, req_we_lo;
    logic [DATA_WIDTH-1:0] req_hi, req_lo;

    logic                  mem_we_hi, mem_we_lo;
    logic [DATA_WIDTH-1:0] mem_hi, mem_lo;
    logic                  wb_we_hi, wb_we_lo;
    logic [DATA_WIDTH-1:0] wb_hi, wb_lo;

    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_WIDTH-1:0] fwd_hi, fwd_lo;

    always_comb begin
        req_we_hi = 1'b0;
        req_we_lo = 1'b0;
        req_hi    = '0;
        req_lo    = '0;
        case (decode_op(ex_valid, ex_funct))
            OP_MULT: begin
                req_we_hi = 1'b1;
                req_we_lo = 1'b1;
                req_hi    = ex_product[2*DATA_WIDTH-1:DATA_WIDTH];
                req_lo    = ex_product[DATA_WIDTH-1:0];
            end
            OP_MTHI: begin
                req_we_hi = 1'b1;
                req_hi    = ex_operand;
            end
            OP_MTLO: begin
                req_we_lo = 1'b1;
                req_lo    = ex_operand;
            end
            default: ;
        endcase
    end

    hilo_stage_reg #(.DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .we_hi_i (req_we_hi),
        .we_lo_i (req_we_lo),
        .hi_i    (req_hi),
        .lo_i    (req_lo),
        .we_hi_o (mem_we_hi),
        .we_lo_o (mem_we_lo),
        .hi_o    (mem_hi),
        .lo_o    (mem_lo)
    );

    hilo_stage_reg #(.DATA_WIDTH(DATA_WIDTH)) u_wb (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .we_hi_i (mem_we_hi),
        .we_lo_i (mem_we_lo),
        .hi_i    (mem_hi),
        .lo_i    (mem_lo),
        .we_hi_o (wb_we_hi),
        .we_lo_o (wb_we_lo),
        .hi_o    (wb_hi),
        .lo_o    (wb_lo)
    );

    // A flush still retires the WB entry: it is older than the faulting instruction.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (flush || !stall) begin
            if (wb_we_hi) hi_d = wb_hi;
            if (wb_we_lo) lo_d = wb_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        fwd_hi = mem_we_hi ? mem_hi : (wb_we_hi ? wb_hi : hi_q);
        fwd_lo = mem_we_lo ? mem_lo : (wb_we_lo ? wb_lo : lo_q);
    end

    always_comb begin
        ex_rdata = '0;
        case (ex_funct)
            FUNCT_MFHI: ex_rdata = fwd_hi;
            FUNCT_MFLO: ex_rdata = fwd_lo;
            default:    ex_rdata = '0;
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: vector table for forwarding/latency, hand sequences for stall, flush, reset.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    localparam logic [5:0] FUNCT_NOP = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid;
    logic [5:0]  ex_funct;
    logic [31:0] ex_operand;
    logic [63:0] ex_product;
    logic [31:0] ex_rdata, hi, lo;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic        valid;
        logic [5:0]  funct;
        logic [31:0] operand;
        logic [63:0] product;
        logic [31:0] exp_rdata;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    hilo_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_funct   (ex_funct),
        .ex_operand (ex_operand),
        .ex_product (ex_product),
        .ex_rdata   (ex_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one EX cycle at the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic st, input logic fl, input logic v, input logic [5:0] f,
                       input logic [31:0] op, input logic [63:0] prod);
        @(negedge clk);
        stall      = st;
        flush      = fl;
        ex_valid   = v;
        ex_funct   = f;
        ex_operand = op;
        ex_product = prod;
        #1;
    endtask

    task automatic chk3(input string tag, input logic [31:0] er, input logic [31:0] eh,
                        input logic [31:0] el);
        chk({tag, ".rdata"}, ex_rdata, er);
        chk({tag, ".hi"}, hi, eh);
        chk({tag, ".lo"}, lo, el);
    endtask

    initial begin
        // MULT latency / forwarding
        vecs.push_back('{1'b1, FUNCT_MULT, 32'h0, 64'hFFFF_FFFF_FFFF_FFFA, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, FUNCT_MFHI, 32'h0, 64'h0, 32'hFFFF_FFFF, 32'h0, 32'h0});
        vecs.push_back('{1'b1, FUNCT_MFLO, 32'h0, 64'h0, 32'hFFFF_FFFA, 32'h0, 32'h0});
        vecs.push_back('{1'b1, FUNCT_NOP,  32'h0, 64'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        // MTHI then MULTU back-to-back
        vecs.push_back('{1'b1, FUNCT_MTHI,  32'h1234_5678, 64'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{1'b1, FUNCT_MULTU, 32'h0, 64'h0000_0001_0000_0002, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{1'b1, FUNCT_MFHI,  32'h0, 64'h0, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{1'b1, FUNCT_MFLO,  32'h0, 64'h0, 32'h0000_0002, 32'h1234_5678, 32'hFFFF_FFFA});
        vecs.push_back('{1'b1, FUNCT_NOP,   32'h0, 64'h0, 32'h0, 32'h1, 32'h2});
        // Invalid slot / non-HI/LO funct create no entry
        vecs.push_back('{1'b0, FUNCT_MULT, 32'h0, 64'hDEAD_BEEF_0BAD_CAFE, 32'h0, 32'h1, 32'h2});
        vecs.push_back('{1'b1, FUNCT_ADD,  32'h5, 64'h1357_9BDF_2468_ACE0, 32'h0, 32'h1, 32'h2});
        vecs.push_back('{1'b1, FUNCT_MFHI, 32'h0, 64'h0, 32'h1, 32'h1, 32'h2});
        vecs.push_back('{1'b1, FUNCT_MFLO, 32'h0, 64'h0, 32'h2, 32'h1, 32'h2});
        // Independent halves: MTHI in MEM, MULT in WB
        vecs.push_back('{1'b1, FUNCT_MULT, 32'h0, 64'h1111_1111_2222_2222, 32'h0, 32'h1, 32'h2});
        vecs.push_back('{1'b1, FUNCT_MTHI, 32'h3333_3333, 64'h0, 32'h0, 32'h1, 32'h2});
        vecs.push_back('{1'b1, FUNCT_MFLO, 32'h0, 64'h0, 32'h2222_2222, 32'h1, 32'h2});
        vecs.push_back('{1'b1, FUNCT_MFHI, 32'h0, 64'h0, 32'h3333_3333, 32'h1111_1111, 32'h2222_2222});
        vecs.push_back('{1'b1, FUNCT_NOP,  32'h0, 64'h0, 32'h0, 32'h3333_3333, 32'h2222_2222});

        rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
        ex_funct = FUNCT_NOP; ex_operand = '0; ex_product = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.hi", hi, 32'h0);
        chk("reset.lo", lo, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(1'b0, 1'b0, vecs[i].valid, vecs[i].funct, vecs[i].operand, vecs[i].product);
            chk3($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Stall: MTLO held in MEM for three cycles, commits two edges after release
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MTLO, 32'hAAAA_AAAA, 64'h0);
        chk3("stall_issue", 32'h0, 32'h3333_3333, 32'h2222_2222);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, FUNCT_MFLO, 32'h0, 64'h0);
            chk3($sformatf("stall_hold%0d", i), 32'hAAAA_AAAA, 32'h3333_3333, 32'h2222_2222);
        end
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MFLO, 32'h0, 64'h0);
        chk3("stall_rel0", 32'hAAAA_AAAA, 32'h3333_3333, 32'h2222_2222);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MFLO, 32'h0, 64'h0);
        chk3("stall_rel1", 32'hAAAA_AAAA, 32'h3333_3333, 32'h2222_2222);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_NOP, 32'h0, 64'h0);
        chk3("stall_done", 32'h0, 32'h3333_3333, 32'hAAAA_AAAA);

        // Flush (with stall also high): WB MULT commits, MEM MTHI dropped
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MULT, 32'h0, 64'h0BAD_F00D_CAFE_BABE);
        chk3("flush_mult", 32'h0, 32'h3333_3333, 32'hAAAA_AAAA);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MTHI, 32'h7777_7777, 64'h0);
        chk3("flush_mthi", 32'h0, 32'h3333_3333, 32'hAAAA_AAAA);
        cyc(1'b1, 1'b1, 1'b1, FUNCT_MFHI, 32'h0, 64'h0);
        chk3("flush_cyc", 32'h7777_7777, 32'h3333_3333, 32'hAAAA_AAAA);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MFHI, 32'h0, 64'h0);
        chk3("flush_mfhi", 32'h0BAD_F00D, 32'h0BAD_F00D, 32'hCAFE_BABE);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MFLO, 32'h0, 64'h0);
        chk3("flush_mflo", 32'hCAFE_BABE, 32'h0BAD_F00D, 32'hCAFE_BABE);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_NOP, 32'h0, 64'h0);
        chk3("flush_done", 32'h0, 32'h0BAD_F00D, 32'hCAFE_BABE);

        // Asynchronous reset with MEM and WB both populated
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MULT, 32'h0, 64'h0000_0005_0000_0006);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MTLO, 32'h0000_0009, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MFHI, 32'h0, 64'h0);
        chk3("rst_pre", 32'h0000_0005, 32'h0BAD_F00D, 32'hCAFE_BABE);
        #1 rst = 1'b1;
        #1;
        chk3("rst_async", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ex_funct = FUNCT_MFHI;
        #1;
        chk3("rst_mfhi", 32'h0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_MFLO, 32'h0, 64'h0);
        chk3("rst_mflo", 32'h0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, FUNCT_NOP, 32'h0, 64'h0);
        chk3("rst_done", 32'h0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
